// File: rtl/sc_ifu_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC select,
// fetch FSM states and the default reset vector.
package sc_ifu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_REG    = 2'd2,
    PC_JUMP   = 2'd3
  } pcsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection: sequential, PC-relative branch, register jump and
// region-relative absolute jump. All arithmetic wraps modulo 2^32.
module sc_npc
  import sc_ifu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] inst_i,
  input  logic [31:0] ra_i,
  input  pcsel_e      pcsource_i,
  output logic [31:0] pc4_o,
  output logic [31:0] npc_o
);

  logic [31:0] br_off;

  assign pc4_o  = pc_i + 32'd4;
  assign br_off = {{14{inst_i[15]}}, inst_i[15:0], 2'b00};

  always_comb begin
    npc_o = pc4_o;
    unique case (pcsource_i)
      PC_SEQ:    npc_o = pc4_o;
      PC_BRANCH: npc_o = pc4_o + br_off;
      PC_REG:    npc_o = ra_i;
      PC_JUMP:   npc_o = {pc4_o[31:28], inst_i, 2'b00};
      default:   npc_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: fetches one word per instruction, holds it while
// the datapath executes, then advances the PC or halts on a misaligned target.
module sc_ifu
  import sc_ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] npc;

  sc_npc u_npc (
    .pc_i       (pc_q),
    .inst_i     (inst_q[25:0]),
    .ra_i       (ra),
    .pcsource_i (pcsel_e'(pcsource)),
    .pc4_o      (pc4),
    .npc_o      (npc)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RESET;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        inst_valid = 1'b1;
        // A misaligned target leaves pc pointing at the faulting instruction.
        if (!hold) begin
          if (misaligned(npc)) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = npc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: err = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;

endmodule

// File: tb/tb_sc_ifu.sv
// Directed bench for sc_ifu: expected fetch addresses are queued by the
// stimulus and popped by a monitor on every accepted memory read.
module tb_sc_ifu;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] ra;
  logic        hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        err;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sc_ifu #(.PC_RESET(RST_PC)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .ra         (ra),
    .hold       (hold),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .err        (err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Tiny control unit: opcode low bits select the next-PC source.
  assign imem_rdata = rd(imem_addr);
  assign pcsource   = inst[27:26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (imem_req === 1'b1 && imem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
      end else begin
        chk("fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    mem[32'h0000_000C] = {6'd3, 26'h000_0040};          // j 0x100
    mem[32'h0000_0100] = {6'd1, 10'd0, 16'hFFFE};       // branch -8 -> 0xFC
    mem[32'h0000_00FC] = {6'd3, 26'h010_0004};          // j 0x0040_0010
    mem[32'h0040_0010] = {6'd3, 26'h000_0020};          // j 0x80
    mem[32'h0000_0080] = 32'h0000_0000;                 // sequential
    mem[32'h0000_0084] = {6'd2, 26'h0};                 // jr ra

    resetn = 1'b0; imem_ready = 1'b1; hold = 1'b0; ra = 32'h0000_0103;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("valid_pattern", {31'b0, inst_valid}, (i % 2 == 1) ? 32'h1 : 32'h0);
    end

    @(posedge clock); #1;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_req", {31'b0, imem_req}, 32'h1);
      chk("stall_addr", imem_addr, 32'h0000_000C);
      chk("stall_valid", {31'b0, inst_valid}, 32'h0);
    end
    @(posedge clock); #1;
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_00FC);
    exp_q.push_back(32'h0040_0010);
    exp_q.push_back(32'h0000_0080);
    exp_q.push_back(32'h0000_0084);
    imem_ready = 1'b1;
    @(negedge clock);
    chk("ready_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clock);
    chk("exec_valid", {31'b0, inst_valid}, 32'h1);
    chk("exec_inst", inst, {6'd3, 26'h000_0040});
    chk("exec_pc4", pc4, 32'h0000_0010);

    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (inst_valid === 1'b1 && pc === 32'h0000_0080) found = 1'b1;
    end
    chk("reach_0x80", {31'b0, found}, 32'h1);
    hold = 1'b1;
    @(negedge clock);
    chk("hold_valid1", {31'b0, inst_valid}, 32'h1);
    chk("hold_pc1", pc, 32'h0000_0080);
    @(negedge clock);
    chk("hold_valid2", {31'b0, inst_valid}, 32'h1);
    chk("hold_pc2", pc, 32'h0000_0080);
    hold = 1'b0;
    @(negedge clock);
    chk("hold_release_valid", {31'b0, inst_valid}, 32'h0);
    chk("hold_release_pc", pc, 32'h0000_0084);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (err === 1'b1) found = 1'b1;
    end
    chk("halt_err", {31'b0, found}, 32'h1);
    chk("halt_pc", pc, 32'h0000_0084);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("halt_req", {31'b0, imem_req}, 32'h0);
      chk("halt_valid", {31'b0, inst_valid}, 32'h0);
      chk("halt_err_sticky", {31'b0, err}, 32'h1);
    end

    imem_ready = 1'b0;
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("rerst_pc", pc, RST_PC);
    chk("rerst_err", {31'b0, err}, 32'h0);
    chk("rerst_inst", inst, 32'h0);
    chk("rerst_req", {31'b0, imem_req}, 32'h0);
    @(negedge clock);
    chk("rerst_fetch_req", {31'b0, imem_req}, 32'h1);
    chk("rerst_fetch_addr", imem_addr, RST_PC);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
